// File: rtl/piezo_arbiter.sv
// piezo_arbiter: shares one piezo tone generator between three sound sources.
// Source priority is alarm (2), then lullaby (1), then key-click (0). A grant
// must run for MIN_HOLD cycles before a higher source may preempt it. Every
// change of owner is separated by GAP_CYCLES cycles of silence.
// Optional feature macro: SOUND_TIMEOUT_EN. When it is defined, a grant is
// cut off after MAX_PLAY cycles and that source is locked out until its
// request drops.
module piezo_arbiter #(
    parameter int NOTE_W     = 13,
    parameter int GAP_CYCLES = 1000,
    parameter int MIN_HOLD   = 50000,
    parameter int MAX_PLAY   = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [NOTE_W-1:0] note0,
    input  logic [NOTE_W-1:0] note1,
    input  logic [NOTE_W-1:0] note2,
    output logic [2:0]        grant,
    output logic [NOTE_W-1:0] beat_out,
    output logic              busy,
    output logic              preempted
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

    // Reject parameter values the counters are not sized for
    if (GAP_CYCLES < 1 || GAP_CYCLES > (1 << 20)) begin : g_bad_gap
        $error("piezo_arbiter: GAP_CYCLES out of range 1..2^20");
    end
    if (MIN_HOLD < 0 || MIN_HOLD > (1 << 24)) begin : g_bad_hold
        $error("piezo_arbiter: MIN_HOLD out of range 0..2^24");
    end
    if (MAX_PLAY < 1) begin : g_bad_play
        $error("piezo_arbiter: MAX_PLAY must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [NOTE_W-1:0]   beat_q, beat_d;
    logic                busy_q, busy_d;
    logic                pre_q, pre_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic [2:0]          avail;     // requests eligible for arbitration
    logic [2:0]          pick;      // one-hot winner among avail
    logic [2:0]          higher;    // sources that outrank the current owner
    logic [NOTE_W-1:0]   pick_note;
    logic [NOTE_W-1:0]   own_note;
    logic                release_w;

`ifdef SOUND_TIMEOUT_EN
    localparam int PLAY_W = $clog2(MAX_PLAY + 1);
    logic [PLAY_W-1:0]   play_q, play_d;
    logic [2:0]          mask_q, mask_d;
    assign avail = req & ~mask_q;
`else
    assign avail = req;
`endif

    // Fixed-priority pick: highest set bit wins
    always_comb begin
        pick = 3'b000;
        if (avail[2])      pick = 3'b100;
        else if (avail[1]) pick = 3'b010;
        else if (avail[0]) pick = 3'b001;
    end

    // Bits strictly above the current one-hot owner
    always_comb begin
        higher = 3'b000;
        case (grant_q)
            3'b001:  higher = 3'b110;
            3'b010:  higher = 3'b100;
            default: higher = 3'b000;
        endcase
    end

    assign pick_note = ({NOTE_W{pick[0]}} & note0) | ({NOTE_W{pick[1]}} & note1)
                     | ({NOTE_W{pick[2]}} & note2);
    assign own_note  = ({NOTE_W{grant_q[0]}} & note0) | ({NOTE_W{grant_q[1]}} & note1)
                     | ({NOTE_W{grant_q[2]}} & note2);
    assign release_w = ~|(req & grant_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        grant_d = 3'b000;
        beat_d  = '0;
        busy_d  = 1'b1;
        pre_d   = 1'b0;
        hold_d  = hold_q;
        gap_d   = gap_q;
`ifdef SOUND_TIMEOUT_EN
        play_d  = play_q;
        mask_d  = mask_q & req;   // lockout lifts once the source lets go
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (|avail) begin
                    state_d = S_GRANT;
                    grant_d = pick;
                    beat_d  = pick_note;
                    busy_d  = 1'b1;
                    hold_d  = '0;
`ifdef SOUND_TIMEOUT_EN
                    play_d  = '0;
`endif
                end
            end
            S_GRANT: begin
                if (release_w) begin
                    // Release wins over a simultaneous preempt: no pulse
                    state_d = S_GAP;
                    gap_d   = '0;
`ifdef SOUND_TIMEOUT_EN
                end else if (play_q == PLAY_W'(MAX_PLAY - 1)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    mask_d  = mask_d | grant_q;
`endif
                end else if ((|(avail & higher)) && hold_q == HOLD_W'(MIN_HOLD)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    pre_d   = 1'b1;
                end else begin
                    grant_d = grant_q;
                    beat_d  = own_note;
                    if (hold_q != HOLD_W'(MIN_HOLD)) hold_d = hold_q + 1'b1;
`ifdef SOUND_TIMEOUT_EN
                    if (play_q != PLAY_W'(MAX_PLAY)) play_d = play_q + 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    // Requests are only looked at on the last silent cycle
                    if (|avail) begin
                        state_d = S_GRANT;
                        grant_d = pick;
                        beat_d  = pick_note;
                        hold_d  = '0;
`ifdef SOUND_TIMEOUT_EN
                        play_d  = '0;
`endif
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset silences the piezo at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            pre_q   <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

`ifdef SOUND_TIMEOUT_EN
    // Play-length counter and sticky lockout mask
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            play_q <= '0;
            mask_q <= 3'b000;
        end else begin
            play_q <= play_d;
            mask_q <= mask_d;
        end
    end
`endif

    assign grant     = grant_q;
    assign beat_out  = beat_q;
    assign busy      = busy_q;
    assign preempted = pre_q;

endmodule

// File: tb/tb_piezo_arbiter.sv
// tb_piezo_arbiter: directed checks of arbitration, hold window, gap, reset
// and (when SOUND_TIMEOUT_EN is defined) the play timeout and lockout.
module tb_piezo_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [12:0] n0 = 13'h011, n1 = 13'h022, n2 = 13'h033;
    logic [2:0]  grant;
    logic [12:0] beat_out;
    logic        busy, preempted;
    logic [17:0] obs;
    int          n_chk = 0;
    int          n_fail = 0;

`ifdef SOUND_TIMEOUT_EN
    localparam int HOLD1 = 15;
`else
    localparam int HOLD1 = 20;
`endif

    piezo_arbiter #(.NOTE_W(13), .GAP_CYCLES(4), .MIN_HOLD(8), .MAX_PLAY(16)) dut (
        .clk(clk), .rst(rst), .req(req), .note0(n0), .note1(n1), .note2(n2),
        .grant(grant), .beat_out(beat_out), .busy(busy), .preempted(preempted)
    );

    always #5 clk = ~clk;

    assign obs = {grant, beat_out, busy, preempted};

    function automatic logic [17:0] ev(logic [2:0] g, logic [12:0] b, logic bz, logic p);
        return {g, b, bz, p};
    endfunction

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // grant must never have more than one bit set
    always @(negedge clk) begin
        if (rst) begin
            n_chk++;
            if (!$onehot0(grant)) begin n_fail++; $display("FAIL grant_onehot: got %b want zero or one-hot", grant); end
        end
    end

    task automatic test_reset();
        rst = 1'b0; req = 3'b000;
        step(2);
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
        rst = 1'b1;
        step(2);
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL idle_no_req: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
    endtask

    task automatic test_release();
        req = 3'b010;
        step();
        n_chk++; if (obs !== ev(3'b010, 13'h022, 1'b1, 1'b0)) begin n_fail++; $display("FAIL grant_latency: got %h want %h", obs, ev(3'b010, 13'h022, 1'b1, 1'b0)); end
        step(HOLD1 - 1);
        n_chk++; if (obs !== ev(3'b010, 13'h022, 1'b1, 1'b0)) begin n_fail++; $display("FAIL grant_held: got %h want %h", obs, ev(3'b010, 13'h022, 1'b1, 1'b0)); end
        req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b1, 1'b0)) begin n_fail++; $display("FAIL release_gap[%0d]: got %h want %h", i, obs, ev(3'b000, 13'h000, 1'b1, 1'b0)); end
        end
        step();
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL idle_after_gap: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
    endtask

    task automatic test_preempt();
        req = 3'b001;
        step();
        n_chk++; if (obs !== ev(3'b001, 13'h011, 1'b1, 1'b0)) begin n_fail++; $display("FAIL grant_src0: got %h want %h", obs, ev(3'b001, 13'h011, 1'b1, 1'b0)); end
        step(3);
        req = 3'b101;                       // alarm arrives at hold=3
        for (int i = 4; i <= 8; i++) begin
            step();
            n_chk++; if (obs !== ev(3'b001, 13'h011, 1'b1, 1'b0)) begin n_fail++; $display("FAIL hold_window[%0d]: got %h want %h", i, obs, ev(3'b001, 13'h011, 1'b1, 1'b0)); end
        end
        step();
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b1, 1'b1)) begin n_fail++; $display("FAIL preempt_pulse: got %h want %h", obs, ev(3'b000, 13'h000, 1'b1, 1'b1)); end
        for (int i = 1; i < 4; i++) begin
            step();
            n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b1, 1'b0)) begin n_fail++; $display("FAIL preempt_gap[%0d]: got %h want %h", i, obs, ev(3'b000, 13'h000, 1'b1, 1'b0)); end
        end
        step();
        n_chk++; if (obs !== ev(3'b100, 13'h033, 1'b1, 1'b0)) begin n_fail++; $display("FAIL grant_after_preempt: got %h want %h", obs, ev(3'b100, 13'h033, 1'b1, 1'b0)); end
    endtask

    task automatic test_low_no_preempt();
        req = 3'b110;                       // owner 2 keeps it despite req[1]
        for (int i = 0; i < 10; i++) begin
            step();
            n_chk++; if (obs !== ev(3'b100, 13'h033, 1'b1, 1'b0)) begin n_fail++; $display("FAIL low_no_preempt[%0d]: got %h want %h", i, obs, ev(3'b100, 13'h033, 1'b1, 1'b0)); end
        end
        req = 3'b010;
        step();
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b1, 1'b0)) begin n_fail++; $display("FAIL release_no_pulse: got %h want %h", obs, ev(3'b000, 13'h000, 1'b1, 1'b0)); end
        step(4);
        n_chk++; if (obs !== ev(3'b010, 13'h022, 1'b1, 1'b0)) begin n_fail++; $display("FAIL grant_low_after_gap: got %h want %h", obs, ev(3'b010, 13'h022, 1'b1, 1'b0)); end
    endtask

    task automatic test_release_vs_preempt();
        step(8);                            // owner 1 reaches hold=8
        req = 3'b100;                       // drop 1 and raise 2 on one edge
        step();
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b1, 1'b0)) begin n_fail++; $display("FAIL simultaneous_no_pulse: got %h want %h", obs, ev(3'b000, 13'h000, 1'b1, 1'b0)); end
        step(4);
        n_chk++; if (obs !== ev(3'b100, 13'h033, 1'b1, 1'b0)) begin n_fail++; $display("FAIL simultaneous_regrant: got %h want %h", obs, ev(3'b100, 13'h033, 1'b1, 1'b0)); end
        req = 3'b000;
        step(5);
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL back_to_idle: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
    endtask

    task automatic test_note_passthrough();
        req = 3'b010;
        step();
        n1 = 13'h0AB;
        step();
        n_chk++; if (obs !== ev(3'b010, 13'h0AB, 1'b1, 1'b0)) begin n_fail++; $display("FAIL owner_note_change: got %h want %h", obs, ev(3'b010, 13'h0AB, 1'b1, 1'b0)); end
        n0 = 13'h1FF; n2 = 13'h155;
        step();
        n_chk++; if (obs !== ev(3'b010, 13'h0AB, 1'b1, 1'b0)) begin n_fail++; $display("FAIL non_owner_notes: got %h want %h", obs, ev(3'b010, 13'h0AB, 1'b1, 1'b0)); end
        n0 = 13'h011; n1 = 13'h022; n2 = 13'h033;
        step();
        n_chk++; if (obs !== ev(3'b010, 13'h022, 1'b1, 1'b0)) begin n_fail++; $display("FAIL note_restore: got %h want %h", obs, ev(3'b010, 13'h022, 1'b1, 1'b0)); end
    endtask

    task automatic test_reset_mid_grant();
        #2 rst = 1'b0;
        #1;                                 // well before the next clock edge
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL async_reset_clear: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
        req = 3'b000;
        step();
        rst = 1'b1;
        step(3);
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL idle_after_reset_release: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
    endtask

`ifdef SOUND_TIMEOUT_EN
    task automatic test_timeout();
        req = 3'b010;
        step();
        n_chk++; if (obs !== ev(3'b010, 13'h022, 1'b1, 1'b0)) begin n_fail++; $display("FAIL timeout_grant: got %h want %h", obs, ev(3'b010, 13'h022, 1'b1, 1'b0)); end
        step(15);
        n_chk++; if (obs !== ev(3'b010, 13'h022, 1'b1, 1'b0)) begin n_fail++; $display("FAIL timeout_last_cycle: got %h want %h", obs, ev(3'b010, 13'h022, 1'b1, 1'b0)); end
        step();
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b1, 1'b0)) begin n_fail++; $display("FAIL timeout_gap: got %h want %h", obs, ev(3'b000, 13'h000, 1'b1, 1'b0)); end
        step(4);
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL timeout_locked_idle: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
        step(3);
        n_chk++; if (obs !== ev(3'b000, 13'h000, 1'b0, 1'b0)) begin n_fail++; $display("FAIL timeout_stays_locked: got %h want %h", obs, ev(3'b000, 13'h000, 1'b0, 1'b0)); end
        req = 3'b000;
        step();
        req = 3'b010;
        step();
        n_chk++; if (obs !== ev(3'b010, 13'h022, 1'b1, 1'b0)) begin n_fail++; $display("FAIL timeout_regrant: got %h want %h", obs, ev(3'b010, 13'h022, 1'b1, 1'b0)); end
        req = 3'b000;
        step(6);
    endtask
`endif

    initial begin
        test_reset();
        test_release();
        test_preempt();
        test_low_no_preempt();
        test_release_vs_preempt();
        test_note_passthrough();
        test_reset_mid_grant();
`ifdef SOUND_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/piezo_arbiter.md
Name: piezo_arbiter

Overview:
- Shares the single piezo tone generator between three sound sources: alarm (req[2]), lullaby player (req[1]), key-click beep (req[0]).
- Sits between the sound-sequencer FSMs and the piezo block: selects one 13-bit note code per cycle and drives the piezo's playSound input.
- Fixed priority with a minimum-hold window, so a lower-priority tune is not chopped every cycle.
- Inserts a silent gap between ownership changes so tones do not run together.

Parameters:
- NOTE_W, 13, width of note codes (matches piezo playSound).
- GAP_CYCLES, 1000, silent cycles between any two grants; legal range 1..2^20.
- MIN_HOLD, 50000, cycles a grant must run before higher-priority preemption is allowed; legal range 0..2^24.
- MAX_PLAY, 100000000, grant length limit (used only with SOUND_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  3  request per source; level, held for the whole tune
- note0  in  NOTE_W  current note code, source 0
- note1  in  NOTE_W  current note code, source 1
- note2  in  NOTE_W  current note code, source 2
- grant  out  3  one-hot owner; 0 when nobody owns the piezo
- beat_out  out  NOTE_W  note code to piezo; 0 = silence (musicOff)
- busy  out  1  1 in GRANT or GAP
- preempted  out  1  one-cycle pulse when a grant ends by preemption

Behaviour:
- Reset (rst=0, async): state=IDLE; grant=0, beat_out=0, busy=0, preempted=0; all counters cleared.
- All outputs are registered.
- Priority: 2 > 1 > 0.
- IDLE:
  - Any req bit set at an edge -> GRANT to the highest set bit.
  - grant and busy are valid the following cycle (1-cycle latency).
- GRANT:
  - beat_out = registered copy of note[owner], so 1-cycle latency from the note input.
  - hold counter starts at 0 on entry and increments each cycle, saturating at MIN_HOLD.
  - Exit to GAP when req[owner] deasserts ("release").
  - Exit to GAP when a higher-index req is set and hold==MIN_HOLD ("preempt"); preempted pulses for exactly 1 cycle, coincident with the first GAP cycle.
  - Lower-priority requests never preempt.
  - Release and preempt in the same cycle: treated as release; no preempted pulse.
- GAP:
  - grant=0, beat_out=0, busy=1.
  - gap counter counts GAP_CYCLES cycles.
  - On the last gap cycle, sample req: any bit set -> GRANT to the highest set bit; else -> IDLE (busy=0 next cycle).
  - Request changes during GAP are ignored until gap end.
- Note changes from the owner mid-grant pass straight through; no gap is inserted.
- Notes from non-owners never reach beat_out.
- Reset mid-grant silences the piezo immediately (async clear of beat_out).
- Counter widths are $clog2(param+1); no wrap-around; all counters saturate.
- grant is always zero or one-hot; asserting it not one-hot is a bench check.

Optional Feature:
- Macro: SOUND_TIMEOUT_EN.
- Defined:
  - A play counter runs during GRANT.
  - At MAX_PLAY cycles the grant is forced to GAP, handled like a release (no preempted pulse).
  - The owner's bit is set in a sticky lockout mask; masked sources are ignored by arbitration.
  - A source's mask bit clears when its req deasserts.
  - Reset clears the mask.
  - This protects against a stuck sequencer droning forever.
- Undefined: no play counter and no mask; a grant lasts until release or preemption. MAX_PLAY is unused.

Test Plan (GAP_CYCLES=4, MIN_HOLD=8, note0=0x011, note1=0x022, note2=0x033):
- req=010 from IDLE, held 20 cycles then dropped -> grant=010 and beat_out=0x022 one cycle after req; after the drop, grant=0 and beat_out=0 for 4 cycles, then IDLE with busy=0.
- req=001 granted, req[2] set at hold=3 -> source 0 keeps playing until hold=8; then preempted=1 for 1 cycle, 4-cycle gap, then grant=100 and beat_out=0x033.
- Owner=2, req[1] set -> no preemption ever; when req[2] drops, 4-cycle gap, then grant=010.
- req[1] dropped and req[2] raised on the same edge at hold=8 -> preempted stays 0; gap, then grant=100.
- Reset asserted mid-grant with beat_out=0x022 -> beat_out=0 and grant=0 without waiting for a clock edge; after release with req=000 -> stays IDLE.
- With SOUND_TIMEOUT_EN and MAX_PLAY=16, req=010 held -> grant ends after 16 cycles, then 4-cycle gap, then IDLE while req[1] is still high; drop and re-raise req[1] -> granted again.
